// File: rtl/bist_sched_pkg.sv
// bist_sched_pkg: widths, FSM state encodings and signature constants shared
// by the BIST scheduler top (bist_sched) and its window counter (bist_cnt).
// No ports.

package bist_sched_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int SIG_W  = 32;
  localparam int CNT_W  = 16;

  // ORA register value immediately after a clear.
  localparam logic [SIG_W-1:0] SIG_SEED  = 32'h0000_0001;
  // Signature reported for an aborted session.
  localparam logic [SIG_W-1:0] SIG_ABORT = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_COMPACT = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

endpackage

// File: rtl/bist_cnt.sv
// bist_cnt: 16-bit loadable down-counter with zero flag. Times the COMPACT
// window of a BIST session.
// Ports:
//   clk, rst_n   clock, async active-low reset (count resets to 0)
//   load         load load_val this cycle (has priority over dec)
//   dec          decrement by one; holds at zero
//   load_val     value to load
//   zero         count is zero

module bist_cnt
  import bist_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/bist_sched.sv
// bist_sched: BIST session scheduler and ORA port arbiter. Shares the single
// ORA access port between the CPU memory-mapped path and a session engine
// that clears the ORA, compacts cfg_len response beats, then captures and
// compares the signature.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   start, cfg_len, golden          session request and its parameters
//   resp_valid/data/addr, resp_ready  CUT response stream
//   cpu_req/we/addr/wdata, cpu_gnt, cpu_rdata  CPU path to the ORA
//   ora_addr/wdata/we/clr, ora_rdata           ORA access port
//   busy, done, pass, signature                session status and result
// Optional feature: define BIST_ABORT_EN to add the 'abort' input, which ends
// a session from CLEAR or COMPACT with pass=0 and an all-ones signature.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | waiting for start; CPU may own the ORA port
// ST_CLEAR   | one cycle, ora_clr high, window counter loaded
// ST_COMPACT | cfg_len cycles, response stream drives the ORA
// ST_CAPTURE | one cycle, latch ORA value and compare with golden
// ST_DONE    | one cycle, done high; CPU may own the ORA port

module bist_sched
  import bist_sched_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  cfg_len,
  input  logic [SIG_W-1:0]  golden,
  input  logic              resp_valid,
  input  logic [DATA_W-1:0] resp_data,
  input  logic [ADDR_W-1:0] resp_addr,
  output logic              resp_ready,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic [SIG_W-1:0]  cpu_rdata,
  output logic [ADDR_W-1:0] ora_addr,
  output logic [DATA_W-1:0] ora_wdata,
  output logic              ora_we,
  output logic              ora_clr,
  input  logic [SIG_W-1:0]  ora_rdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [SIG_W-1:0]  signature
`ifdef BIST_ABORT_EN
  ,
  input  logic              abort
`endif
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [SIG_W-1:0]  golden_q, golden_d;
  logic [SIG_W-1:0]  sig_q, sig_d;
  logic              pass_q, pass_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              clr_q, clr_d;
  logic              cnt_load, cnt_dec, cnt_zero;
  logic              abort_i;

`ifdef BIST_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  // Counter holds len-1 on the first COMPACT cycle, so reaching zero marks
  // the last window cycle; a 0xFFFF window never has to count through zero.
  bist_cnt u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (len_q - {{(CNT_W-1){1'b0}}, 1'b1}),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    golden_d = golden_q;
    sig_d    = sig_q;
    pass_d   = pass_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_CLEAR;
          len_d    = cfg_len;
          golden_d = golden;
        end
      end
      ST_CLEAR: begin
        cnt_load = 1'b1;
        if (abort_i) begin
          state_d = ST_DONE;
          sig_d   = SIG_ABORT;
          pass_d  = 1'b0;
        end else if (len_q != '0) begin
          state_d = ST_COMPACT;
        end else begin
          state_d = ST_CAPTURE;
        end
      end
      ST_COMPACT: begin
        cnt_dec = 1'b1;
        if (abort_i) begin
          state_d = ST_DONE;
          sig_d   = SIG_ABORT;
          pass_d  = 1'b0;
        end else if (cnt_zero) begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        state_d = ST_DONE;
        sig_d   = ora_rdata;
        pass_d  = (ora_rdata == golden_q);
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_CLEAR) || (state_d == ST_COMPACT) ||
             (state_d == ST_CAPTURE);
    done_d = (state_d == ST_DONE);
    clr_d  = (state_d == ST_CLEAR);
  end

  // ORA is held cleared throughout reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      len_q    <= '0;
      golden_q <= '0;
      sig_q    <= '0;
      pass_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      clr_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      golden_q <= golden_d;
      sig_q    <= sig_d;
      pass_q   <= pass_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      clr_q    <= clr_d;
    end
  end

  // A start in IDLE wins the port over a same-cycle CPU request.
  assign cpu_gnt = rst_n && cpu_req &&
                   ((state_q == ST_IDLE) || (state_q == ST_DONE)) &&
                   !((state_q == ST_IDLE) && start);

  assign resp_ready = (state_q == ST_COMPACT);

  always_comb begin
    ora_addr  = '0;
    ora_wdata = '0;
    ora_we    = 1'b0;
    if (state_q == ST_COMPACT) begin
      ora_addr  = resp_addr;
      ora_wdata = resp_data;
      ora_we    = resp_valid;
    end else if (cpu_gnt) begin
      ora_addr  = cpu_addr;
      ora_wdata = cpu_wdata;
      ora_we    = cpu_we;
    end
  end

  assign cpu_rdata = ora_rdata;
  assign ora_clr   = clr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign signature = sig_q;

endmodule

// File: tb/tb_bist_sched.sv
// tb_bist_sched: scoreboard bench for bist_sched with a behavioural stand-in
// for the trcd ORA (seed 1 on clear, shifts every cycle, XORs in writes).

module tb_bist_sched;

  localparam logic [31:0] POLY = 32'h04C1_1DB7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] cfg_len;
  logic [31:0] golden;
  logic        resp_valid;
  logic [15:0] resp_data, resp_addr;
  logic        resp_ready;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr, cpu_wdata;
  logic        cpu_gnt;
  logic [31:0] cpu_rdata;
  logic [15:0] ora_addr, ora_wdata;
  logic        ora_we, ora_clr;
  logic [31:0] ora_rdata;
  logic        busy, done, pass;
  logic [31:0] signature;
`ifdef BIST_ABORT_EN
  logic        abort;
`endif

  bist_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cfg_len    (cfg_len),
    .golden     (golden),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_addr  (resp_addr),
    .resp_ready (resp_ready),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rdata  (cpu_rdata),
    .ora_addr   (ora_addr),
    .ora_wdata  (ora_wdata),
    .ora_we     (ora_we),
    .ora_clr    (ora_clr),
    .ora_rdata  (ora_rdata),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .signature  (signature)
`ifdef BIST_ABORT_EN
    ,
    .abort      (abort)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ora_step(logic [31:0] r, logic we, logic [15:0] wd);
    logic [31:0] n;
    n = {r[30:0], 1'b0} ^ (r[31] ? POLY : 32'h0);
    if (we) n = n ^ {16'h0, wd};
    return n;
  endfunction

  function automatic logic [31:0] ref_sig(int len);
    logic [31:0] r;
    r = 32'h1;
    for (int i = 0; i < len; i++) r = ora_step(r, 1'b0, 16'h0);
    return r;
  endfunction

  // ORA stand-in
  logic [31:0] ora_q;
  always @(posedge clk) begin
    if (ora_clr) ora_q <= 32'h1;
    else         ora_q <= ora_step(ora_q, ora_we, ora_wdata);
  end
  assign ora_rdata = ora_q;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [31:0] sig;
    logic        pass;
    int          done_cyc;
  } exp_t;
  exp_t sbq[$];

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done=1 with no session outstanding (cyc %0d)", cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("signature", signature, e.sig);
        chk("pass", {31'h0, pass}, {31'h0, e.pass});
        chk("done_cycle", cyc, e.done_cyc);
      end
    end
  end

  // Issues start; returns at the next negedge (CLEAR cycle) with start low.
  task automatic start_session(input logic [15:0] len, input logic [31:0] gold,
                               input logic [31:0] exp_sig, input logic exp_pass,
                               input int done_ofs);
    @(negedge clk);
    start   = 1'b1;
    cfg_len = len;
    golden  = gold;
    sbq.push_back('{sig: exp_sig, pass: exp_pass, done_cyc: cyc + done_ofs});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sbq.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: %0d sessions outstanding after %0d cycles", sbq.size(), budget);
      sbq.delete();
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; cfg_len = '0; golden = '0;
    resp_valid = 1'b0; resp_data = '0; resp_addr = '0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 16'h0BEE;
`ifdef BIST_ABORT_EN
    abort = 1'b0;
`endif

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ora_clr", {31'h0, ora_clr}, 32'h1);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_pass", {31'h0, pass}, 32'h0);
    chk("rst_signature", signature, 32'h0);
    chk("rst_cpu_gnt", {31'h0, cpu_gnt}, 32'h0);
    chk("rst_resp_ready", {31'h0, resp_ready}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("clr_release", {31'h0, ora_clr}, 32'h0);
    chk("idle_cpu_gnt", {31'h0, cpu_gnt}, 32'h1);
    chk("idle_cpu_we", {31'h0, ora_we}, 32'h1);
    chk("idle_cpu_addr", {16'h0, ora_addr}, 32'h0010);

    // Start/CPU tie, cfg_len=0 session
    @(negedge clk);
    start = 1'b1; cfg_len = 16'd0; golden = 32'h1;
    sbq.push_back('{sig: 32'h1, pass: 1'b1, done_cyc: cyc + 3});
    #1;
    chk("tie_cpu_gnt", {31'h0, cpu_gnt}, 32'h0);
    chk("tie_ora_we", {31'h0, ora_we}, 32'h0);
    @(negedge clk);
    start = 1'b0; cpu_req = 1'b0;
    chk("clear_ora_clr", {31'h0, ora_clr}, 32'h1);
    chk("clear_busy", {31'h0, busy}, 32'h1);
    wait_drain(20);

    start_session(16'd1, 32'h2, 32'h2, 1'b1, 4);
    wait_drain(20);
    start_session(16'd2, 32'h0, 32'h4, 1'b0, 5);
    wait_drain(20);

    resp_valid = 1'b1;
    start_session(16'd1, 32'h3, 32'h2, 1'b0, 4);
    wait_drain(20);

    // Nonzero response data, compaction port routing
    resp_data = 16'h00F0; resp_addr = 16'h1234;
    start_session(16'd1, 32'hF2, 32'hF2, 1'b1, 4);
    @(negedge clk);
    #1;
    chk("compact_ready", {31'h0, resp_ready}, 32'h1);
    chk("compact_we", {31'h0, ora_we}, 32'h1);
    chk("compact_addr", {16'h0, ora_addr}, 32'h1234);
    chk("compact_wdata", {16'h0, ora_wdata}, 32'h00F0);
    wait_drain(20);
    resp_valid = 1'b0; resp_data = '0; resp_addr = '0;

    // Start while busy is ignored
    start_session(16'd3, 32'h8, 32'h8, 1'b1, 6);
    start = 1'b1; cfg_len = 16'd0; golden = 32'h0;
    @(negedge clk);
    start = 1'b0;
    wait_drain(20);

    // Start in DONE is ignored
    start_session(16'd0, 32'h1, 32'h1, 1'b1, 3);
    n = 0;
    while (!done && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", {31'h0, done}, 32'h1);
    start = 1'b1;
    @(negedge clk);
    #1;
    chk("start_in_done_busy", {31'h0, busy}, 32'h0);
    start = 1'b0;
    wait_drain(10);

    // CPU request held across a cfg_len=5 session
    start_session(16'd5, 32'h20, 32'h20, 1'b1, 8);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'hA5A5; cpu_wdata = 16'h5A5A;
    #1;
    n = 0;
    while (!cpu_gnt && n < 20) begin
      n++;
      @(negedge clk);
      #1;
    end
    chk("cpu_blocked_cycles", n, 7);
    chk("cpu_gnt_in_done", {31'h0, done}, 32'h1);
    chk("cpu_ora_we", {31'h0, ora_we}, 32'h1);
    chk("cpu_ora_addr", {16'h0, ora_addr}, 32'hA5A5);
    chk("cpu_ora_wdata", {16'h0, ora_wdata}, 32'h5A5A);
    wait_drain(10);
    cpu_req = 1'b0; cpu_we = 1'b0;

    // Maximum window length
    start_session(16'hFFFF, ref_sig(65535), ref_sig(65535), 1'b1, 65538);
    wait_drain(70000);

`ifdef BIST_ABORT_EN
    // Abort on the third COMPACT cycle
    start_session(16'd10, 32'h0, 32'hFFFF_FFFF, 1'b0, 5);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_drain(20);
`endif

    // Reset in the middle of a long session
    start_session(16'd100, 32'h0, 32'h0, 1'b0, 103);
    repeat (10) @(negedge clk);
    chk("mid_ready", {31'h0, resp_ready}, 32'h1);
    cpu_req = 1'b1;
    rst_n = 1'b0;
    sbq.delete();
    #1;
    chk("mid_rst_busy", {31'h0, busy}, 32'h0);
    chk("mid_rst_clr", {31'h0, ora_clr}, 32'h1);
    chk("mid_rst_pass", {31'h0, pass}, 32'h0);
    chk("mid_rst_sig", signature, 32'h0);
    chk("mid_rst_done", {31'h0, done}, 32'h0);
    chk("mid_rst_ready", {31'h0, resp_ready}, 32'h0);
    chk("mid_rst_gnt", {31'h0, cpu_gnt}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cpu_req = 1'b0;
    repeat (120) @(negedge clk);
    chk("post_rst_busy", {31'h0, busy}, 32'h0);
    chk("post_rst_queue", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bist_sched.md
# bist_sched

BIST session scheduler and port arbiter for the trcd output-response analyser (32-bit MISR/LFSR signature register). It shares the single ORA access port between the CPU memory-mapped path and a BIST session engine. A session runs clear, then a fixed-length compaction window, then signature capture and golden compare. It sits between the mips_16 data-memory decode, the circuit-under-test response source and the trcd instance.

## Interface
- No parameters. Widths come from shared defines: address 16, data 16, signature 32.
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  session start pulse; sampled in IDLE only
- cfg_len  in  16  compaction window length in cycles; sampled on accepted start
- golden  in  32  expected signature; sampled on accepted start
- resp_valid  in  1  CUT response beat present
- resp_data  in  16  CUT response data
- resp_addr  in  16  CUT response address
- resp_ready  out  1  high in every COMPACT cycle, low otherwise
- cpu_req / cpu_we  in  1 / 1  CPU access request / write
- cpu_addr / cpu_wdata  in  16 / 16  CPU address / write data
- cpu_gnt  out  1  CPU owns ORA port this cycle (combinational)
- cpu_rdata  out  32  ORA read data passthrough
- ora_addr / ora_wdata  out  16 / 16  to trcd mem_access_addr / mem_write_data
- ora_we  out  1  to trcd mem_write_en
- ora_clr  out  1  registered, active-high; drives trcd rst
- ora_rdata  in  32  from trcd mem_read_data
- busy  out  1  session in progress
- done  out  1  one-cycle pulse at session end
- pass  out  1  sticky compare result
- signature  out  32  sticky captured signature

## Operation
- States: IDLE, CLEAR, COMPACT, CAPTURE, DONE.
- IDLE: start=1 goes to CLEAR and latches cfg_len and golden. Otherwise stay in IDLE.
- CLEAR: exactly 1 cycle with ora_clr=1. Goes to COMPACT when the latched length is nonzero, else to CAPTURE.
- COMPACT: exactly the latched length in cycles, counted down by a 16-bit counter.
  - ora_addr=resp_addr, ora_wdata=resp_data, ora_we=resp_valid.
  - The ORA shifts every cycle whether or not a write occurs. The signature therefore depends on the per-cycle resp_valid pattern, and the source must be cycle-deterministic.
- CAPTURE: 1 cycle. ora_addr=0 (raw register), ora_we=0. signature<=ora_rdata; pass<=(ora_rdata==golden).
- DONE: 1 cycle, done=1, then IDLE.
- Port mux: the CPU drives the ORA when cpu_gnt=1. Otherwise in IDLE/DONE, ora_we=0 and ora_addr/ora_wdata=0.
- cpu_gnt = cpu_req & (IDLE or DONE) & ~(IDLE & start). Start wins a same-cycle tie.
- CPU requests during a session are not queued; the CPU holds cpu_req until granted.
- busy=1 in CLEAR, COMPACT and CAPTURE.

## Timing
- Reset values: state IDLE, ora_clr=1 (ORA held cleared while in reset), busy=0, done=0, pass=0, signature=0, counter=0. cpu_gnt and resp_ready are 0 during reset.
- ora_clr deasserts on the first clock after rst_n rises.
- Latency from start to done pulse: cfg_len+3 cycles (CLEAR + COMPACT + CAPTURE, then DONE).
- Signature equals the ORA register after exactly cfg_len updates from seed 0x00000001.
- start while busy: ignored. start in DONE: ignored; it must be re-issued in IDLE.
- cfg_len=0xFFFF: counter must not wrap early; the window is exactly 65535 cycles.
- rst_n assertion mid-session: immediate return to IDLE, pass and signature cleared, no done pulse.

## Configuration
- BIST_ABORT_EN defined:
  - Adds input abort (1 bit).
  - abort=1 in CLEAR or COMPACT goes to DONE next cycle: done pulses, pass=0, signature=0xFFFFFFFF.
  - abort is ignored in IDLE, CAPTURE and DONE.
- BIST_ABORT_EN undefined: no abort port; every session runs to completion.

## Structure
- State encodings (3-bit) and the SIG_SEED=32'h1 constant go in the shared mips_16_defs header, next to the other `define constants.
- One sub-module: bist_cnt, a 16-bit loadable down-counter with zero flag used for the COMPACT window.
- Top-level bist_sched holds the FSM, sticky result registers and port mux. It does not instantiate trcd.

## Test plan
- cfg_len=0, start -> CLEAR, CAPTURE, DONE; signature=0x00000001; pass=1 with golden=0x1.
- cfg_len=1, resp_valid=0 -> signature=0x00000002. cfg_len=2, resp_valid=0 -> signature=0x00000004.
- cfg_len=1, resp_valid=1, resp_data=0, resp_addr=0 -> signature=0x00000002. With golden=0x3 -> pass=0; done pulses at cycle 4 after start.
- cpu_req held across a session with cfg_len=5 -> cpu_gnt=0 for 7 cycles. It rises in the DONE cycle, and the CPU write reaches ora_we.
- rst_n pulsed low during COMPACT of a cfg_len=100 session -> IDLE, busy=0, no done pulse, ora_clr=1 during reset.
- With BIST_ABORT_EN: abort on the 3rd COMPACT cycle -> done next cycle, pass=0, signature=0xFFFFFFFF.
